// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the MIPS execute stage.
// Stalls F/D/E while busy and returns {hi,lo} with a one-cycle done pulse.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_CYC = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        startE,
    input  logic [1:0]  opE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        cancel,
    output logic        stallE,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_a, r_b, r_rem, r_quot, r_hi, r_lo;
    logic        r_dsign, r_qsign;

    logic        w_start, w_sa, w_sb, w_ge;
    logic [31:0] w_mag_a, w_mag_b, w_diff, w_rem_nx, w_quot_nx;
    logic [32:0] w_rem_sh;
    logic [63:0] w_prod_mag, w_prod;

    // NOTE: state register uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        stallE = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: if (startE && !cancel) begin
                stallE = 1'b1;
                w_next = opE[1] ? S_DIV : S_MUL;
            end
            S_MUL: begin
                stallE = 1'b1;
                if (cancel)              w_next = S_IDLE;
                else if (r_cnt == 5'd0)  w_next = S_DONE;
            end
            S_DIV: begin
                stallE = 1'b1;
                if (cancel)              w_next = S_IDLE;
                else if (r_cnt == 5'd0)  w_next = S_DONE;
            end
            S_DONE: begin
                done   = !cancel;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Signed ops work on magnitudes; signs are re-applied on the way out.
    assign w_start = (r_state == S_IDLE) && startE && !cancel;
    assign w_sa    = !opE[0] && srcaE[31];
    assign w_sb    = !opE[0] && srcbE[31];
    assign w_mag_a = w_sa ? -srcaE : srcaE;
    assign w_mag_b = w_sb ? -srcbE : srcbE;

    assign w_prod_mag = {32'd0, r_a} * {32'd0, r_b};
    assign w_prod     = r_qsign ? -w_prod_mag : w_prod_mag;

    // One restoring-division step: shift in the next dividend bit, trial-subtract.
    assign w_rem_sh  = {r_rem, r_quot[31]};
    assign w_ge      = w_rem_sh >= {1'b0, r_b};
    assign w_diff    = w_rem_sh[31:0] - r_b;
    assign w_rem_nx  = w_ge ? w_diff : w_rem_sh[31:0];
    assign w_quot_nx = {r_quot[30:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_rem   <= '0;
            r_quot  <= '0;
            r_dsign <= 1'b0;
            r_qsign <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (w_start) begin
            r_a     <= w_mag_a;
            r_b     <= w_mag_b;
            r_rem   <= '0;
            r_quot  <= w_mag_a;
            r_dsign <= w_sa;
            r_qsign <= w_sa ^ w_sb;
            r_cnt   <= opE[1] ? 5'(DIV_CYC - 1) : 5'(MUL_LAT - 1);
        end else if (r_state == S_MUL && !cancel) begin
            if (r_cnt == 5'd0) {r_hi, r_lo} <= w_prod;
            else               r_cnt <= r_cnt - 5'd1;
        end else if (r_state == S_DIV && !cancel) begin
            r_rem  <= w_rem_nx;
            r_quot <= w_quot_nx;
            if (r_cnt == 5'd0) begin
                r_lo <= r_qsign ? -w_quot_nx : w_quot_nx;
                r_hi <= r_dsign ? -w_rem_nx  : w_rem_nx;
            end else begin
                r_cnt <= r_cnt - 5'd1;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: driver queues expected {hi,lo}, monitor
// compares on every done pulse; driver also checks stall length and latency.
module tb_muldiv_ctrl;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, startE, cancel;
    logic [1:0]  opE;
    logic [31:0] srcaE, srcbE;
    logic        stallE, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_err    = 0;
    logic [63:0] sb[$];
    logic [63:0] last_res;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_CYC(32)) dut (
        .clk(clk), .rst(rst), .startE(startE), .opE(opE),
        .srcaE(srcaE), .srcbE(srcbE), .cancel(cancel),
        .stallE(stallE), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h, expected no done", hi, lo);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("result_hilo", {hi, lo}, e);
            end
        end
    end

    // Issue one operation, hold startE through DONE, then drop it for one idle cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        int cyc, stalls, lat;
        bit seen;
        lat = op[1] ? 33 : MUL_LAT + 1;
        @(posedge clk); #1;
        startE = 1'b1; opE = op; srcaE = a; srcbE = b;
        sb.push_back(exp);
        last_res = exp;
        cyc = 0; stalls = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (stallE) stalls++;
            if (done) seen = 1'b1;
            else      cyc++;
        end
        check("done_seen", 64'(seen), 64'd1);
        check("done_latency", 64'(cyc), 64'(lat));
        check("stall_cycles", 64'(stalls), 64'(lat));
        @(posedge clk); #1;
        startE = 1'b0;
        @(negedge clk);
        check("idle_after_done", {62'd0, stallE, done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; startE = 1'b0; cancel = 1'b0; opE = 2'b00; srcaE = '0; srcbE = '0;
        last_res = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {30'd0, stallE, done, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        #1 rst = 1'b0;

        do_op(2'b01, 32'd3, 32'd5, 64'd15);
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        do_op(2'b00, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
        do_op(2'b11, 32'd100, 32'd7, {32'd2, 32'd14});
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
        do_op(2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'd3});
        do_op(2'b11, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF});
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000});

        // Cancel a divide in cycle 10: no done, hi/lo untouched.
        @(posedge clk); #1;
        startE = 1'b1; opE = 2'b10; srcaE = 32'd1000; srcbE = 32'd3;
        for (int i = 0; i < 10; i++) @(posedge clk);
        #1 cancel = 1'b1;
        @(negedge clk);
        check("cancel_cycle_stall", {62'd0, stallE, done}, 64'd2);
        @(posedge clk); #1;
        cancel = 1'b0; startE = 1'b0;
        @(negedge clk);
        check("after_cancel_stall", {63'd0, stallE}, 64'd0);
        check("after_cancel_hilo", {hi, lo}, last_res);
        do_op(2'b01, 32'd2, 32'd3, 64'd6);

        // Reset in the middle of a divide clears outputs and yields no done.
        @(posedge clk); #1;
        startE = 1'b1; opE = 2'b11; srcaE = 32'd100; srcbE = 32'd7;
        for (int i = 0; i < 20; i++) @(posedge clk);
        #1 rst = 1'b1; startE = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_hilo", {hi, lo}, 64'd0);
        check("mid_rst_ctrl", {62'd0, stallE, done}, 64'd0);
        repeat (40) @(negedge clk);

        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
